// File: rtl/mux_chan_scanner_pkg.sv
// Shared types and constants for the 4:1 mux channel scanner.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2
    } scan_state_e;

endpackage

// File: rtl/mux_chan_scanner_if.sv
// Frame valid/ready bus between the scanner and its downstream consumer.
// frame_parity exists only when SCAN_PARITY_EN is defined.
interface mux_chan_scanner_if;
    import mux_scan_pkg::*;

    logic [NUM_CH-1:0] frame_data;
    logic              frame_valid;
    logic              frame_ready;
`ifdef SCAN_PARITY_EN
    logic              frame_parity;
`endif

    modport master (
`ifdef SCAN_PARITY_EN
        output frame_parity,
`endif
        output frame_data,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
`ifdef SCAN_PARITY_EN
        input  frame_parity,
`endif
        input  frame_data,
        input  frame_valid,
        output frame_ready
    );

endinterface

// File: rtl/mux_chan_scanner_outreg.sv
// Output holding register: keeps a finished frame stable until accepted.
// Optional parity bit under SCAN_PARITY_EN.
module mux_scan_outreg
    import mux_scan_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [NUM_CH-1:0] data_i,
    output logic              free_o,
    mux_chan_scanner_if.master out_if
);

    logic              valid_q;
    logic [NUM_CH-1:0] data_q;

    // A load always wins; a transfer that coincides with a load keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (out_if.frame_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef SCAN_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (load_i) begin
            parity_q <= ^data_i;
        end
    end

    assign out_if.frame_parity = parity_q;
`endif

    assign free_o             = ~valid_q | out_if.frame_ready;
    assign out_if.frame_data  = data_q;
    assign out_if.frame_valid = valid_q;

endmodule

// File: rtl/mux_chan_scanner.sv
// Sequencer for a 4:1 mux: steps s0/s1 through all channels, samples x after
// a settle window and emits 4-bit frames. SCAN_PARITY_EN adds frame_parity.
module mux_chan_scanner
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic continuous,
    input  logic x,
    output logic s0,
    output logic s1,
    output logic busy,
    mux_chan_scanner_if.master frame_if
);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be >= 1");
    end
    if ((1 << CNT_W) < SETTLE_CYCLES) begin : g_bad_cnt_w
        $error("CNT_W too narrow for SETTLE_CYCLES");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    scan_state_e       state_q;
    logic [CH_W-1:0]   ch_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] asm_q;
    logic [NUM_CH-1:0] asm_d;
    logic [NUM_CH-1:0] frame_d;
    logic              busy_q;
    logic              win_end;
    logic              out_free;
    logic              load;

    // On a SCAN completion the last channel's sample is merged in combinationally
    // so the frame can be loaded on the same edge that captures it.
    always_comb begin
        win_end     = (cnt_q == CNT_LAST);
        asm_d       = asm_q;
        asm_d[ch_q] = x;
        frame_d     = (state_q == WAIT) ? asm_q : asm_d;
        load        = out_free &
                      (((state_q == SCAN) & win_end & (ch_q == CH_LAST)) |
                       (state_q == WAIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SCAN;
                        ch_q    <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (!win_end) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                        asm_q <= asm_d;
                        if (ch_q != CH_LAST) begin
                            ch_q <= ch_q + 1'b1;
                        end else if (out_free) begin
                            ch_q <= '0;
                            if (!continuous) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (out_free) begin
                        ch_q <= '0;
                        if (continuous) begin
                            state_q <= SCAN;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    mux_scan_outreg u_outreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .data_i (frame_d),
        .free_o (out_free),
        .out_if (frame_if)
    );

    assign s0   = ch_q[1];
    assign s1   = ch_q[0];
    assign busy = busy_q;

endmodule

// File: tb/tb_mux_chan_scanner.sv
// Bench for mux_chan_scanner: position-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_mux_chan_scanner;

    localparam int S       = 2;
    localparam int M_IDLE  = 0;
    localparam int M_SCAN  = 1;
    localparam int M_WAIT  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       continuous;
    logic       x;
    logic       s0;
    logic       s1;
    logic       busy;
    logic [3:0] y_pat;

    mux_chan_scanner_if bus ();

    mux_chan_scanner #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .x          (x),
        .s0         (s0),
        .s1         (s1),
        .busy       (busy),
        .frame_if   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural 4:1 mux driven by the DUT selects
    assign x = y_pat[{s0, s1}];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scan progress as a cycle position within the 4*S frame
    int         m_mode  = M_IDLE;
    int         m_pos   = 0;
    logic [3:0] m_frame = '0;
    logic [3:0] m_data  = '0;
    logic       m_valid = 1'b0;
    logic       m_par   = 1'b0;
    bit         m_free;
    bit         m_xfer;
    bit         m_load;
    logic [3:0] m_new;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  = M_IDLE;
            m_pos   = 0;
            m_frame = '0;
            m_data  = '0;
            m_valid = 1'b0;
            m_par   = 1'b0;
        end else begin
            m_free = !m_valid || bus.frame_ready;
            m_xfer = m_valid && bus.frame_ready;
            m_load = 1'b0;
            m_new  = m_data;
            case (m_mode)
                M_IDLE: if (start) begin
                    m_mode = M_SCAN;
                    m_pos  = 0;
                end
                M_SCAN: begin
                    if (m_pos % S == S - 1) m_frame[m_pos / S] = y_pat[m_pos / S];
                    if (m_pos == 4 * S - 1) begin
                        if (m_free) begin
                            m_load = 1'b1;
                            m_new  = m_frame;
                            m_mode = continuous ? M_SCAN : M_IDLE;
                            m_pos  = 0;
                        end else begin
                            m_mode = M_WAIT;
                        end
                    end else begin
                        m_pos++;
                    end
                end
                default: if (m_free) begin
                    m_load = 1'b1;
                    m_new  = m_frame;
                    m_mode = continuous ? M_SCAN : M_IDLE;
                    m_pos  = 0;
                end
            endcase
            if (m_load) begin
                m_valid = 1'b1;
                m_data  = m_new;
                m_par   = ^m_new;
            end else if (m_xfer) begin
                m_valid = 1'b0;
            end
        end
    end

    int         vcount     = 0;
    logic [3:0] last_frame = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            int es;
            es = (m_mode == M_SCAN) ? m_pos / S : (m_mode == M_WAIT) ? 3 : 0;
            check("model_sel",   {30'd0, s0, s1},     es);
            check("model_busy",  {31'd0, busy},       {31'd0, m_mode != M_IDLE});
            check("model_valid", {31'd0, bus.frame_valid}, {31'd0, m_valid});
            check("model_data",  {28'd0, bus.frame_data},  {28'd0, m_data});
`ifdef SCAN_PARITY_EN
            check("model_parity", {31'd0, bus.frame_parity}, {31'd0, m_par});
`endif
            if (bus.frame_valid) begin
                vcount++;
                last_frame = bus.frame_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        continuous      = 1'b0;
        bus.frame_ready = 1'b0;
        y_pat           = 4'b0000;
        chk_en          = 1'b1;

        // Reset and idle
        repeat (3) tick();
        check("rst_sel",   {30'd0, s0, s1}, 0);
        check("rst_busy",  {31'd0, busy}, 0);
        check("rst_valid", {31'd0, bus.frame_valid}, 0);
        check("rst_data",  {28'd0, bus.frame_data}, 0);
        rst_n = 1'b1;
        repeat (4) tick();
        check("idle_busy", {31'd0, busy}, 0);

        // Single scan, y=1010
        y_pat           = 4'b1010;
        bus.frame_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            check("scan_sel",   {30'd0, s0, s1}, i / 2);
            check("scan_valid", {31'd0, bus.frame_valid}, 0);
            tick();
        end
        check("single_valid", {31'd0, bus.frame_valid}, 1);
        check("single_data",  {28'd0, bus.frame_data}, 32'hA);
        check("single_busy",  {31'd0, busy}, 0);
        tick();
        check("single_drop",  {31'd0, bus.frame_valid}, 0);

        // Backpressure with continuous scanning
        repeat (3) tick();
        continuous      = 1'b1;
        bus.frame_ready = 1'b0;
        y_pat           = 4'b0110;
        pulse_start();
        repeat (8) tick();
        check("bp_first_valid", {31'd0, bus.frame_valid}, 1);
        check("bp_first_data",  {28'd0, bus.frame_data}, 32'h6);
        y_pat = 4'b1001;
        repeat (10) tick();
        check("bp_wait_sel",   {30'd0, s0, s1}, 3);
        check("bp_wait_busy",  {31'd0, busy}, 1);
        check("bp_hold_data",  {28'd0, bus.frame_data}, 32'h6);
        bus.frame_ready = 1'b1;
        tick();
        bus.frame_ready = 1'b0;
        check("bp_swap_valid", {31'd0, bus.frame_valid}, 1);
        check("bp_swap_data",  {28'd0, bus.frame_data}, 32'h9);
        check("bp_resume_sel", {30'd0, s0, s1}, 0);
        continuous      = 1'b0;
        bus.frame_ready = 1'b1;
        repeat (10) tick();
        check("bp_end_busy",  {31'd0, busy}, 0);
        check("bp_end_valid", {31'd0, bus.frame_valid}, 0);

        // Start pulses while busy are ignored
        repeat (2) tick();
        y_pat  = 4'b1100;
        vcount = 0;
        pulse_start();
        repeat (2) tick();
        pulse_start();
        tick();
        pulse_start();
        repeat (9) tick();
        check("ign_frames", vcount, 1);
        check("ign_data",   {28'd0, last_frame}, 32'hC);
        check("ign_busy",   {31'd0, busy}, 0);

        // Reset during channel 2
        y_pat = 4'b0101;
        pulse_start();
        repeat (5) tick();
        check("mid_sel", {30'd0, s0, s1}, 2);
        rst_n = 1'b0;
        #1;
        check("arst_sel",   {30'd0, s0, s1}, 0);
        check("arst_busy",  {31'd0, busy}, 0);
        check("arst_valid", {31'd0, bus.frame_valid}, 0);
        check("arst_data",  {28'd0, bus.frame_data}, 0);
        tick();
        rst_n = 1'b1;
        y_pat = 4'b0011;
        tick();
        pulse_start();
        repeat (8) tick();
        check("fresh_valid", {31'd0, bus.frame_valid}, 1);
        check("fresh_data",  {28'd0, bus.frame_data}, 32'h3);

`ifdef SCAN_PARITY_EN
        repeat (3) tick();
        y_pat = 4'b1011;
        pulse_start();
        repeat (8) tick();
        check("par_odd_valid", {31'd0, bus.frame_valid}, 1);
        check("par_odd",       {31'd0, bus.frame_parity}, 1);
        repeat (3) tick();
        y_pat = 4'b1001;
        pulse_start();
        repeat (8) tick();
        check("par_even_valid", {31'd0, bus.frame_valid}, 1);
        check("par_even",       {31'd0, bus.frame_parity}, 0);
`endif

        repeat (3) tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
